ame_num_div: RTL and testbench
==============================

// Module: ame_num_div
// PURPOSE
//  Downstream of the AME number-scaling stage: takes the scaled {M, D, L, C} quadruple and its shift, and computes two
//  signed fixed-point ratios Q_MD = (M<<FRAC_BITS)/D and Q_LC = (L<<FRAC_BITS)/C with an iterative radix-2 restoring
//  divider. Result and the passed-through shift go to the affine-parameter update stage. One op at a time.
// PARAMETERS
//  COMP_DATA_BITS   64   width of each input integer (two's complement)
//  FRAC_BITS        16   fractional bits of each quotient
//  QUOT_BITS        32   quotient width incl. sign (2..COMP_DATA_BITS)
// PORTS
//  clk_i         in   1                          clock
//  rst_n_i       in   1                          async reset, active low
//  comp_init_i   in   1                          start pulse; sampled only in IDLE
//  comp_busy_o   out  1                          high from cycle after accepted init until done
//  comp_done_o   out  1                          one-cycle pulse, results valid
//  comp_shift_i  in   $clog2(COMP_DATA_BITS)     shift from scaling stage, captured with init
//  comp_data_i   in   [3:0][COMP_DATA_BITS]      {M, D, L, C}, captured with init
//  comp_shift_o  out  $clog2(COMP_DATA_BITS)     captured shift, updated with done
//  comp_quot_o   out  [1:0][QUOT_BITS]           [1]=Q_MD, [0]=Q_LC, signed
//  comp_sat_o    out  [1:0]                      quotient saturated (overflow or div-by-zero)
//  comp_dz_o     out  [1:0]                      divisor was zero
// BEHAVIOUR
//  - Single clock clk_i; reset rst_n_i asynchronous, active low. Reset: all outputs 0, FSM IDLE, operands cleared.
//    Reset mid-operation aborts; no done pulse for the aborted op.
//  - FSM: IDLE -> SETUP_MD -> ITER_MD -> SETUP_LC -> ITER_LC -> FIN -> IDLE.
//    IDLE: on comp_init_i, register comp_data_i/comp_shift_i and go to SETUP_MD. init in any other state is ignored.
//    SETUP_x: N=|num|<<FRAC_BITS (COMP_DATA_BITS+FRAC_BITS bits), Dv=|den|, sign=sign(num)^sign(den).
//      dz = (den==0). ovf = (N >> (QUOT_BITS-1)) >= Dv. If dz|ovf: skip ITER, go to the next state.
//      Otherwise rem = N >> (QUOT_BITS-1).
//    ITER_x: exactly QUOT_BITS-1 cycles, MSB first; rem = {rem, N bit}; if rem >= Dv then rem -= Dv and q bit = 1.
//    FIN: apply sign (negate magnitude). Register comp_quot_o/sat/dz/shift_o. Pulse comp_done_o. Drop busy.
//  - Latency: init at cycle T -> done at T+2*QUOT_BITS+1 (65 cycles at defaults), or earlier when an x is skipped.
//    Back-to-back: init may be accepted the cycle after done.
//  - Saturation: magnitude 2^(QUOT_BITS-1)-1, then signed. dz uses sign(num) only (num=0,den=0 -> +max).
//    sat=1 on dz or ovf.
//  - Default rounding: truncation toward zero. Remainder discarded.
//  - Outputs hold their last values between done pulses.
// CONFIGURATION
//  AME_DIV_ROUND_EN defined: after ITER, if 2*rem >= Dv, the magnitude is incremented (round half away from zero).
//    If the increment exceeds the max magnitude, it saturates and sets sat. Latency unchanged.
//  Undefined: truncation only; no rounding logic.
// STRUCTURE
//  - ame_pkg: typedef enum ame_div_state_t {IDLE, SETUP_MD, ITER_MD, SETUP_LC, ITER_LC, FIN}; saturation-magnitude function.
//  - Sub-module ame_div_step: combinational single restoring iteration (rem_i, bit_i, den_i -> rem_o, q_o), one instance
//    shared by both ratios.
//  - Top holds FSM, iteration counter ($clog2(QUOT_BITS) bits), operand/result registers.
// TESTING (defaults FRAC_BITS=16, QUOT_BITS=32)
//  1. M=3, D=2, L=-7, C=2 -> Q_MD=98304, Q_LC=-229376, sat=0, dz=0; done exactly 65 cycles after init; shift_o=shift_i.
//  2. M=2, D=3 -> Q_MD=43690 (no macro) / 43691 (AME_DIV_ROUND_EN).
//     L=-2, C=3 -> -43690 / -43691.
//  3. D=0, M=5 -> Q_MD=0x7FFFFFFF, sat[1]=1, dz[1]=1. C=0, L=-1 -> Q_LC=-0x7FFFFFFF, dz[0]=1.
//     Both skip ITER, so done is early (T+3).
//  4. M=2^40, D=1 -> ovf -> Q_MD=0x7FFFFFFF, sat[1]=1, dz[1]=0. L=-(2^40), C=1 -> -0x7FFFFFFF.
//  5. Assert init on every cycle while busy -> exactly one done per accepted op, operands unchanged mid-op.
//  6. Deassert rst_n_i at iteration 10 of ITER_MD -> outputs 0 immediately, no done. A new op after release completes
//     correctly.

Source files
------------

// File: rtl/ame_pkg.sv
// ame_pkg: shared FSM state type and saturation helper for the AME ratio divider.
package ame_pkg;
  typedef enum logic [2:0] {IDLE, SETUP_MD, ITER_MD, SETUP_LC, ITER_LC, FIN} ame_div_state_t;
  function automatic logic [63:0] ame_sat_mag(input int qb);
    return (64'd1 << (qb - 1)) - 64'd1;
  endfunction
endpackage

// File: rtl/ame_div_step.sv
// ame_div_step: one combinational radix-2 restoring division iteration.
module ame_div_step #(
  parameter int DW = 64
) (
  input  logic [DW-1:0] rem_i,
  input  logic          bit_i,
  input  logic [DW-1:0] den_i,
  output logic [DW-1:0] rem_o,
  output logic          q_o
);
  logic [DW-1:0] t;
  // rem_i < den_i on entry, so the subtracted result always fits in DW bits
  assign t     = {rem_i[DW-2:0], bit_i};
  assign q_o   = rem_i[DW-1] | (t >= den_i);
  assign rem_o = q_o ? t - den_i : t;
endmodule

// File: rtl/ame_num_div.sv
// ame_num_div: computes Q_MD=(M<<FRAC_BITS)/D and Q_LC=(L<<FRAC_BITS)/C with a shared restoring divider.
// Optional AME_DIV_ROUND_EN: round half away from zero instead of truncating.
module ame_num_div
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = 64,
  parameter int FRAC_BITS      = 16,
  parameter int QUOT_BITS      = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              comp_init_i,
  output logic                              comp_busy_o,
  output logic                              comp_done_o,
  input  logic [$clog2(COMP_DATA_BITS)-1:0] comp_shift_i,
  input  logic [3:0][COMP_DATA_BITS-1:0]    comp_data_i,
  output logic [$clog2(COMP_DATA_BITS)-1:0] comp_shift_o,
  output logic [1:0][QUOT_BITS-1:0]         comp_quot_o,
  output logic [1:0]                        comp_sat_o,
  output logic [1:0]                        comp_dz_o
);
  localparam int DW = COMP_DATA_BITS;
  localparam int FB = FRAC_BITS;
  localparam int QB = QUOT_BITS;
  localparam int NW = DW + FB;
  localparam int SW = $clog2(DW);
  localparam int CW = $clog2(QB);
  localparam logic [QB-2:0] MAX_MAG = (QB-1)'(ame_sat_mag(QB));

  ame_div_state_t         state;
  logic [CW-1:0]          cnt;
  logic [3:0][DW-1:0]     op;
  logic [SW-1:0]          shift;
  logic [QB-2:0]          nlow;
  logic [DW-1:0]          dv;
  logic [DW-1:0]          rem;
  logic [QB-2:0]          q;
  logic                   sgn;
  logic [1:0][QB-2:0]     mag;
  logic [1:0]             rsgn;
  logic [1:0]             rsat;
  logic [1:0]             rdz;

  logic                   md;
  logic [DW-1:0]          num;
  logic [DW-1:0]          den;
  logic [DW-1:0]          anum;
  logic [DW-1:0]          aden;
  logic [NW-1:0]          nfull;
  logic [NW-1:0]          nh;
  logic                   dz;
  logic                   ovf;
  logic                   sgn_c;
  logic [DW-1:0]          rem_n;
  logic                   q_bit;
  logic [QB-2:0]          qn;
  logic [QB-2:0]          fmag;
  logic                   fsat;

  ame_div_step #(.DW(DW)) u_step (
    .rem_i (rem),
    .bit_i (nlow[QB-2]),
    .den_i (dv),
    .rem_o (rem_n),
    .q_o   (q_bit)
  );

  always_comb begin
    md    = state == SETUP_MD || state == ITER_MD;
    num   = md ? op[3] : op[1];
    den   = md ? op[2] : op[0];
    anum  = num[DW-1] ? -num : num;
    aden  = den[DW-1] ? -den : den;
    nfull = {anum, {FB{1'b0}}};
    nh    = nfull >> (QB - 1);
    dz    = den == '0;
    ovf   = nh >= NW'(aden);
    sgn_c = dz ? num[DW-1] : num[DW-1] ^ den[DW-1];
    qn    = {q[QB-3:0], q_bit};
`ifdef AME_DIV_ROUND_EN
    fsat  = ({rem_n, 1'b0} >= {1'b0, dv}) && qn == MAX_MAG;
    fmag  = ({rem_n, 1'b0} >= {1'b0, dv}) && qn != MAX_MAG ? qn + (QB-1)'(1) : qn;
`else
    fsat  = 1'b0;
    fmag  = qn;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      cnt          <= '0;
      op           <= '0;
      shift        <= '0;
      nlow         <= '0;
      dv           <= '0;
      rem          <= '0;
      q            <= '0;
      sgn          <= 1'b0;
      mag          <= '0;
      rsgn         <= '0;
      rsat         <= '0;
      rdz          <= '0;
      comp_busy_o  <= 1'b0;
      comp_done_o  <= 1'b0;
      comp_shift_o <= '0;
      comp_quot_o  <= '0;
      comp_sat_o   <= '0;
      comp_dz_o    <= '0;
    end else begin
      comp_done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (comp_init_i) begin
            op          <= comp_data_i;
            shift       <= comp_shift_i;
            comp_busy_o <= 1'b1;
            state       <= SETUP_MD;
          end
        end
        SETUP_MD, SETUP_LC: begin
          dv   <= aden;
          sgn  <= sgn_c;
          nlow <= nfull[QB-2:0];
          rem  <= nh[DW-1:0];
          q    <= '0;
          cnt  <= '0;
          // zero divisor or a quotient too wide for QB bits: emit saturated result, skip iterating
          if (dz || ovf) begin
            mag[md]  <= MAX_MAG;
            rsgn[md] <= sgn_c;
            rsat[md] <= 1'b1;
            rdz[md]  <= dz;
            state    <= md ? SETUP_LC : FIN;
          end else begin
            state    <= md ? ITER_MD : ITER_LC;
          end
        end
        ITER_MD, ITER_LC: begin
          rem  <= rem_n;
          q    <= qn;
          nlow <= nlow << 1;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(QB - 2)) begin
            mag[md]  <= fmag;
            rsgn[md] <= sgn;
            rsat[md] <= fsat;
            rdz[md]  <= 1'b0;
            state    <= md ? SETUP_LC : FIN;
          end
        end
        FIN: begin
          for (int i = 0; i < 2; i++)
            comp_quot_o[i] <= rsgn[i] ? -{1'b0, mag[i]} : {1'b0, mag[i]};
          comp_sat_o   <= rsat;
          comp_dz_o    <= rdz;
          comp_shift_o <= shift;
          comp_done_o  <= 1'b1;
          comp_busy_o  <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ame_num_div.sv
// tb_ame_num_div: scoreboard bench for ame_num_div with directed, hand-computed vectors.
module tb_ame_num_div;
  localparam int DW = 64;
  localparam int QB = 32;
  localparam int SW = 6;
`ifdef AME_DIV_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                init = 1'b0;
  logic                busy, done;
  logic [SW-1:0]       shift_i = '0;
  logic [SW-1:0]       shift_o;
  logic [3:0][DW-1:0]  data = '0;
  logic [1:0][QB-1:0]  quot;
  logic [1:0]          sat, dz;

  ame_num_div dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .comp_init_i  (init),
    .comp_busy_o  (busy),
    .comp_done_o  (done),
    .comp_shift_i (shift_i),
    .comp_data_i  (data),
    .comp_shift_o (shift_o),
    .comp_quot_o  (quot),
    .comp_sat_o   (sat),
    .comp_dz_o    (dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [QB-1:0] q1;
    logic [QB-1:0] q0;
    logic [1:0]    sat;
    logic [1:0]    dz;
    logic [SW-1:0] sh;
    int            lat;
    int            start;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quot_md", 64'(quot[1]), 64'(e.q1));
        chk("quot_lc", 64'(quot[0]), 64'(e.q0));
        chk("sat", 64'(sat), 64'(e.sat));
        chk("dz", 64'(dz), 64'(e.dz));
        chk("shift", 64'(shift_o), 64'(e.sh));
        chk("latency", 64'(cyc - e.start), 64'(e.lat));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic issue(input logic [DW-1:0] m, input logic [DW-1:0] d, input logic [DW-1:0] l,
                       input logic [DW-1:0] c, input logic [SW-1:0] sh, input logic [QB-1:0] e1,
                       input logic [QB-1:0] e0, input logic [1:0] es, input logic [1:0] ed,
                       input int lat, input bit hold);
    exp_t e;
    @(negedge clk);
    data    = {m, d, l, c};
    shift_i = sh;
    init    = 1'b1;
    @(posedge clk);
    #1;
    e = '{e1, e0, es, ed, sh, lat, cyc};
    sb.push_back(e);
    if (!hold) init = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_quot_md"}, 64'(quot[1]), 64'd0);
    chk({tag, "_quot_lc"}, 64'(quot[0]), 64'd0);
    chk({tag, "_sat"}, 64'(sat), 64'd0);
    chk({tag, "_dz"}, 64'(dz), 64'd0);
    chk({tag, "_shift"}, 64'(shift_o), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    // basic fractional ratios, both signs
    issue(64'd3, 64'd2, -64'sd7, 64'd2, 6'd13, 32'd98304, -32'sd229376, 2'b00, 2'b00, 65, 1'b0);
    wait_idle();
    issue(64'd2, 64'd3, -64'sd2, 64'd3, 6'd1, RND ? 32'd43691 : 32'd43690,
          RND ? -32'sd43691 : -32'sd43690, 2'b00, 2'b00, 65, 1'b0);
    wait_idle();
    // divide by zero on both halves: early done
    issue(64'd5, 64'd0, -64'sd1, 64'd0, 6'd63, 32'h7FFF_FFFF, 32'h8000_0001, 2'b11, 2'b11, 3, 1'b0);
    wait_idle();
    // 0/0 saturates positive; negative divisor on the other half
    issue(64'd0, 64'd0, 64'd10, -64'sd4, 6'd7, 32'h7FFF_FFFF, -32'sd163840, 2'b10, 2'b10, 34, 1'b0);
    wait_idle();
    // overflow on both halves
    issue(64'd1 << 40, 64'd1, -(64'sd1 <<< 40), 64'd1, 6'd22, 32'h7FFF_FFFF, 32'h8000_0001, 2'b11, 2'b00, 3, 1'b0);
    wait_idle();
    // overflow boundary: exactly at the limit vs one below
    issue(64'd32768, 64'd1, 64'd32767, 64'd1, 6'd40, 32'h7FFF_FFFF, 32'h7FFF_0000, 2'b10, 2'b00, 34, 1'b0);
    wait_idle();
    // init held high with changing data while busy
    d0 = n_done;
    issue(-64'sd9, -64'sd3, 64'd1, 64'd1, 6'd5, 32'd196608, 32'd65536, 2'b00, 2'b00, 65, 1'b1);
    begin
      int n = 0;
      while (!done && n < 200) begin
        @(negedge clk);
        data    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        shift_i = SW'($urandom);
        n++;
      end
    end
    init = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    chk("hold_done_count", 64'(n_done - d0), 64'd1);
    // async reset during ITER_MD aborts the op
    issue(64'd3, 64'd2, -64'sd7, 64'd2, 6'd9, 32'd98304, -32'sd229376, 2'b00, 2'b00, 65, 1'b0);
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    sb.delete();
    d0 = n_done;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("abort_done_count", 64'(n_done - d0), 64'd0);
    issue(64'd1, 64'd4, -64'sd1, 64'd4, 6'd33, 32'd16384, -32'sd16384, 2'b00, 2'b00, 65, 1'b0);
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
